// File: rtl/pq_cmd_driver.sv
// Single-command initiator for the priority-queue push/pop/drop port.
// Define PQ_DRV_STATS_EN to add saturating op/error counters and their clear input.
module pq_cmd_driver #(
  parameter int unsigned DW       = 32,
  parameter int unsigned ID_WIDTH = 5,
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned STAT_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [1:0]          cmd_op_i,
  input  logic [DW-1:0]       cmd_data_i,
  input  logic [ID_WIDTH-1:0] cmd_id_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [1:0]          rsp_op_o,
  output logic [DW-1:0]       rsp_data_o,
  output logic [ID_WIDTH-1:0] rsp_id_o,
  output logic                rsp_ovf_o,
  output logic                rsp_err_o,
  output logic                pq_push_o,
  output logic                pq_pop_o,
  output logic                pq_drop_o,
  output logic [ID_WIDTH-1:0] pq_drop_id_o,
  output logic [DW-1:0]       pq_data_o,
  input  logic                pq_push_rdy_i,
  input  logic                pq_pop_rdy_i,
  input  logic                pq_drop_rdy_i,
  input  logic [ID_WIDTH-1:0] pq_push_id_i,
  input  logic [DW-1:0]       pq_data_i,
  input  logic                pq_overflow_i,
`ifdef PQ_DRV_STATS_EN
  input  logic                stat_clr_i,
  output logic [STAT_W-1:0]   stat_push_o,
  output logic [STAT_W-1:0]   stat_pop_o,
  output logic [STAT_W-1:0]   stat_drop_o,
  output logic [STAT_W-1:0]   stat_err_o,
`endif
  input  logic [DW-1:0]       pq_data_ovf_i
);

  localparam logic [1:0] OpPush = 2'b00;
  localparam logic [1:0] OpPop  = 2'b01;
  localparam logic [1:0] OpDrop = 2'b10;
  localparam logic [1:0] OpNop  = 2'b11;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_op_q, rsp_op_d;
  logic [DW-1:0]         rsp_data_q, rsp_data_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic                  rsp_ovf_q, rsp_ovf_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  push_q, push_d, pop_q, pop_d, drop_q, drop_d;
  logic [ID_WIDTH-1:0]   drop_id_q, drop_id_d;
  logic [DW-1:0]         pq_data_q, pq_data_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  done, inc_push, inc_pop, inc_drop, inc_err;

  assign done = (push_q & pq_push_rdy_i) | (pop_q & pq_pop_rdy_i) | (drop_q & pq_drop_rdy_i);

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    push_d      = push_q;
    pop_d       = pop_q;
    drop_d      = drop_q;
    drop_id_d   = drop_id_q;
    pq_data_d   = pq_data_q;
    timer_d     = timer_q;
    inc_push    = 1'b0;
    inc_pop     = 1'b0;
    inc_drop    = 1'b0;
    inc_err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          cmd_ready_d = 1'b0;
          rsp_op_d    = cmd_op_i;
          if (cmd_op_i == OpNop) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
            rsp_id_d    = '0;
            rsp_ovf_d   = 1'b0;
            rsp_err_d   = 1'b0;
          end else begin
            state_d   = StIssue;
            timer_d   = '0;
            push_d    = (cmd_op_i == OpPush);
            pop_d     = (cmd_op_i == OpPop);
            drop_d    = (cmd_op_i == OpDrop);
            pq_data_d = (cmd_op_i == OpPush) ? cmd_data_i : '0;
            drop_id_d = (cmd_op_i == OpDrop) ? cmd_id_i : '0;
          end
        end
      end
      StIssue: begin
        if (done || timer_q == TW'(TIMEOUT - 1)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          push_d      = 1'b0;
          pop_d       = 1'b0;
          drop_d      = 1'b0;
          pq_data_d   = '0;
          drop_id_d   = '0;
          rsp_err_d   = ~done;
          rsp_ovf_d   = done & push_q & pq_overflow_i;
          rsp_id_d    = (done & push_q) ? pq_push_id_i : '0;
          rsp_data_d  = '0;
          if (done && pop_q) begin
            rsp_data_d = pq_data_i;
          end else if (done && push_q && pq_overflow_i) begin
            rsp_data_d = pq_data_ovf_i;
          end
          inc_push = done & push_q;
          inc_pop  = done & pop_q;
          inc_drop = done & drop_q;
          inc_err  = ~done;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          state_d     = StIdle;
          cmd_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_op_d    = '0;
          rsp_data_d  = '0;
          rsp_id_d    = '0;
          rsp_ovf_d   = 1'b0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      drop_q      <= 1'b0;
      drop_id_q   <= '0;
      pq_data_q   <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      drop_q      <= drop_d;
      drop_id_q   <= drop_id_d;
      pq_data_q   <= pq_data_d;
      timer_q     <= timer_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_op_o     = rsp_op_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_ovf_o    = rsp_ovf_q;
  assign rsp_err_o    = rsp_err_q;
  assign pq_push_o    = push_q;
  assign pq_pop_o     = pop_q;
  assign pq_drop_o    = drop_q;
  assign pq_drop_id_o = drop_id_q;
  assign pq_data_o    = pq_data_q;

`ifdef PQ_DRV_STATS_EN
  logic [STAT_W-1:0] st_push_q, st_push_d, st_pop_q, st_pop_d;
  logic [STAT_W-1:0] st_drop_q, st_drop_d, st_err_q, st_err_d;

  // Counters saturate at all-ones; clear takes priority over any increment.
  always_comb begin
    st_push_d = st_push_q + STAT_W'(inc_push && st_push_q != '1);
    st_pop_d  = st_pop_q  + STAT_W'(inc_pop  && st_pop_q  != '1);
    st_drop_d = st_drop_q + STAT_W'(inc_drop && st_drop_q != '1);
    st_err_d  = st_err_q  + STAT_W'(inc_err  && st_err_q  != '1);
    if (stat_clr_i) begin
      st_push_d = '0;
      st_pop_d  = '0;
      st_drop_d = '0;
      st_err_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_push_q <= '0;
      st_pop_q  <= '0;
      st_drop_q <= '0;
      st_err_q  <= '0;
    end else begin
      st_push_q <= st_push_d;
      st_pop_q  <= st_pop_d;
      st_drop_q <= st_drop_d;
      st_err_q  <= st_err_d;
    end
  end

  assign stat_push_o = st_push_q;
  assign stat_pop_o  = st_pop_q;
  assign stat_drop_o = st_drop_q;
  assign stat_err_o  = st_err_q;
`endif

endmodule
